// File: rtl/genie_arb_pkg.sv
// rtl/genie_arb_pkg.sv - shared mode encodings and client ids for the memory arbiter
package genie_arb_pkg;

    typedef enum logic {
        ARB_MODE_STATIC = 1'b0,
        ARB_MODE_RR     = 1'b1
    } arb_mode_e;

    // Client ids equal the decoder layer_type codes so sel can be wired straight through
    localparam int CLIENT_FC = 0;
    localparam int CLIENT_CV = 1;
    localparam int CLIENT_MP = 2;

endpackage

// File: rtl/genie_arb_tagfifo.sv
// rtl/genie_arb_tagfifo.sv - in-order tag FIFO recording which client owns each outstanding read
module genie_arb_tagfifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [PW:0]   o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    // A full FIFO still takes a push when the same cycle frees a slot
    assign w_push  = i_push & (~o_full | i_pop);
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end

endmodule

// File: rtl/genie_mem_arbiter.sv
// rtl/genie_mem_arbiter.sv - N-client static/round-robin arbiter for the shared memory port
// GENIE_ARB_RDREG_EN registers c_rready/c_rdata (+1 cycle response latency).
module genie_mem_arbiter
    import genie_arb_pkg::*;
#(
    parameter int NCLIENT = 4,
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int MAXOUT  = 8,
    parameter int IDW     = $clog2(NCLIENT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [IDW-1:0]         sel,
    input  logic [NCLIENT-1:0]     c_wvalid,
    output logic [NCLIENT-1:0]     c_wready,
    input  logic [NCLIENT*AW-1:0]  c_waddr,
    input  logic [NCLIENT*DW-1:0]  c_wdata,
    input  logic [NCLIENT-1:0]     c_rvalid,
    output logic [NCLIENT-1:0]     c_raccept,
    input  logic [NCLIENT*AW-1:0]  c_raddr,
    output logic [NCLIENT-1:0]     c_rready,
    output logic [DW-1:0]          c_rdata,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    output logic [AW-1:0]          m_waddr,
    output logic [DW-1:0]          m_wdata,
    output logic                   m_rvalid,
    input  logic                   m_raccept,
    output logic [AW-1:0]          m_raddr,
    input  logic                   m_rdvalid,
    input  logic [DW-1:0]          m_rdata,
    output logic [$clog2(MAXOUT):0] rd_pending,
    output logic                   err
);

    // Returns {valid, id}; RR scans downwards so the nearest requester at/after ptr wins
    function automatic logic [IDW:0] f_pick(input logic [NCLIENT-1:0] req, input logic md,
                                            input logic [IDW-1:0] s, input logic [IDW-1:0] ptr);
        int idx;
        f_pick = '0;
        if (md == ARB_MODE_RR) begin
            for (int k = NCLIENT - 1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % NCLIENT;
                if (req[idx]) f_pick = {1'b1, IDW'(idx)};
            end
        end else if (int'(s) < NCLIENT && req[s]) begin
            f_pick = {1'b1, s};
        end
    endfunction

    function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] g);
        return IDW'((int'(g) + 1) % NCLIENT);
    endfunction

    logic [1:0][NCLIENT-1:0] w_req;
    logic [1:0]              w_gv;
    logic [1:0]              w_lock_req;
    logic [1:0]              w_xfer;
    logic [1:0][IDW-1:0]     w_gid;
    logic [IDW-1:0]          w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_rd_block;
    logic [NCLIENT-1:0]      w_rsel;
    logic                    r_err;

    assign w_req[0] = c_wvalid;
    assign w_req[1] = c_rvalid;

    // Channel 0 = write, channel 1 = read; identical grant/lock rules
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic           r_lock;
        logic [IDW-1:0] r_id;
        logic [IDW-1:0] r_ptr;
        logic [IDW:0]   w_pick;

        assign w_pick         = f_pick(w_req[ch], mode, sel, r_ptr);
        assign w_gv[ch]       = r_lock | w_pick[IDW];
        assign w_gid[ch]      = r_lock ? r_id : w_pick[IDW-1:0];
        assign w_lock_req[ch] = w_gv[ch] & w_req[ch][w_gid[ch]];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lock <= 1'b0;
                r_id   <= '0;
                r_ptr  <= '0;
            end else if (w_xfer[ch]) begin
                r_lock <= 1'b0;
                r_ptr  <= f_next(w_gid[ch]);
            end else if (w_lock_req[ch]) begin
                r_lock <= 1'b1;
                r_id   <= w_gid[ch];
            end
        end
    end

    assign m_wvalid  = w_lock_req[0];
    assign w_xfer[0] = w_lock_req[0] & m_wready;
    assign m_waddr   = w_gv[0] ? c_waddr[int'(w_gid[0])*AW +: AW] : '0;
    assign m_wdata   = w_gv[0] ? c_wdata[int'(w_gid[0])*DW +: DW] : '0;
    assign c_wready  = w_xfer[0] ? (NCLIENT'(1) << w_gid[0]) : '0;

    // A response in the same cycle frees a tag slot, so a full FIFO need not stall then
    assign w_pop      = m_rdvalid & ~w_empty;
    assign w_rd_block = w_full & ~w_pop;
    assign m_rvalid   = w_lock_req[1] & ~w_rd_block;
    assign w_xfer[1]  = m_rvalid & m_raccept;
    assign m_raddr    = w_gv[1] ? c_raddr[int'(w_gid[1])*AW +: AW] : '0;
    assign c_raccept  = w_xfer[1] ? (NCLIENT'(1) << w_gid[1]) : '0;

    genie_arb_tagfifo #(
        .DEPTH (MAXOUT),
        .W     (IDW)
    ) u_tagfifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_xfer[1]),
        .i_pop   (w_pop),
        .i_din   (w_gid[1]),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (rd_pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_err <= 1'b0;
        else if (m_rdvalid && w_empty) r_err <= 1'b1;
    end
    assign err = r_err;

    assign w_rsel = w_pop ? (NCLIENT'(1) << w_head) : '0;

`ifdef GENIE_ARB_RDREG_EN
    logic [NCLIENT-1:0] r_rready;
    logic [DW-1:0]      r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rready <= '0;
            r_rdata  <= '0;
        end else begin
            r_rready <= w_rsel;
            if (w_pop) r_rdata <= m_rdata;
        end
    end
    assign c_rready = r_rready;
    assign c_rdata  = r_rdata;
`else
    assign c_rready = w_rsel;
    assign c_rdata  = m_rdata;
`endif

endmodule

// File: tb/tb_genie_mem_arbiter.sv
// tb/tb_genie_mem_arbiter.sv - directed self-checking bench for genie_mem_arbiter
module tb_genie_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 26;
    localparam int DW = 32;
`ifdef GENIE_ARB_RDREG_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    logic            clk;
    logic            rst;
    logic            mode;
    logic [1:0]      sel;
    logic [NC-1:0]   c_wvalid;
    logic [NC-1:0]   c_wready;
    logic [NC*AW-1:0] c_waddr;
    logic [NC*DW-1:0] c_wdata;
    logic [NC-1:0]   c_rvalid;
    logic [NC-1:0]   c_raccept;
    logic [NC*AW-1:0] c_raddr;
    logic [NC-1:0]   c_rready;
    logic [DW-1:0]   c_rdata;
    logic            m_wvalid;
    logic            m_wready;
    logic [AW-1:0]   m_waddr;
    logic [DW-1:0]   m_wdata;
    logic            m_rvalid;
    logic            m_raccept;
    logic [AW-1:0]   m_raddr;
    logic            m_rdvalid;
    logic [DW-1:0]   m_rdata;
    logic [3:0]      rd_pending;
    logic            err;

    int n_cmp = 0;
    int n_bad = 0;

    genie_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .sel        (sel),
        .c_wvalid   (c_wvalid),
        .c_wready   (c_wready),
        .c_waddr    (c_waddr),
        .c_wdata    (c_wdata),
        .c_rvalid   (c_rvalid),
        .c_raccept  (c_raccept),
        .c_raddr    (c_raddr),
        .c_rready   (c_rready),
        .c_rdata    (c_rdata),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .m_waddr    (m_waddr),
        .m_wdata    (m_wdata),
        .m_rvalid   (m_rvalid),
        .m_raccept  (m_raccept),
        .m_raddr    (m_raddr),
        .m_rdvalid  (m_rdvalid),
        .m_rdata    (m_rdata),
        .rd_pending (rd_pending),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One memory response followed by an idle cycle; c_rready expected now or next cycle
    task automatic resp(input logic [3:0] exp_rdy, input logic [31:0] data, input string tag);
        logic [3:0]  rdy0;
        logic [3:0]  rdy1;
        logic [31:0] d0;
        logic [31:0] d1;
        step();
        m_rdvalid = 1'b1;
        m_rdata   = data;
        #3;
        rdy0 = c_rready;
        d0   = c_rdata;
        step();
        m_rdvalid = 1'b0;
        #3;
        rdy1 = c_rready;
        d1   = c_rdata;
        chk({tag, "_rdy_now"}, 64'(rdy0), (RL == 0) ? 64'(exp_rdy) : 64'd0);
        chk({tag, "_rdy_next"}, 64'(rdy1), (RL == 1) ? 64'(exp_rdy) : 64'd0);
        chk({tag, "_data"}, (RL == 0) ? 64'(d0) : 64'(d1), 64'(data));
    endtask

    initial begin
        int j;
        int exp_pend;
        rst = 1'b1; mode = 1'b0; sel = '0;
        c_wvalid = '0; c_rvalid = '0; c_waddr = '0; c_wdata = '0; c_raddr = '0;
        m_wready = 1'b0; m_raccept = 1'b0; m_rdvalid = 1'b0; m_rdata = '0;

        // Reset state
        step(); step(); #3;
        chk("rst_m_wvalid", 64'(m_wvalid), 64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_pending", 64'(rd_pending), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_c_rready", 64'(c_rready), 64'd0);
        chk("rst_c_wready", 64'(c_wready), 64'd0);
        step(); rst = 1'b0;
        for (int i = 0; i < NC; i++) begin
            c_waddr[i*AW +: AW] = AW'(32'h100 + i);
            c_wdata[i*DW +: DW] = 32'hD0 + i;
            c_raddr[i*AW +: AW] = AW'(32'h200 + i);
        end

        // Static write, sel=1, clients 0..2 requesting
        step(); mode = 1'b0; sel = 2'd1; c_wvalid = 4'b0111; m_wready = 1'b1; #3;
        chk("st_wready", 64'(c_wready), 64'b0010);
        chk("st_waddr", 64'(m_waddr), 64'h101);
        chk("st_wdata", 64'(m_wdata), 64'hD1);
        chk("st_wvalid", 64'(m_wvalid), 64'd1);
        step(); m_wready = 1'b0; #3;
        chk("wlock_wready", 64'(c_wready), 64'd0);
        chk("wlock_waddr", 64'(m_waddr), 64'h101);
        step(); mode = 1'b1; sel = 2'd0; m_wready = 1'b1; #3;
        chk("wlock_hold", 64'(c_wready), 64'b0010);
        step(); #3;
        chk("wrr_c2", 64'(c_wready), 64'b0100);
        chk("wrr_c2_addr", 64'(m_waddr), 64'h102);
        step(); #3;
        chk("wrr_wrap", 64'(c_wready), 64'b0001);
        step(); c_wvalid = '0; #3;
        chk("w_idle", 64'(m_wvalid), 64'd0);

        // RR reads from all four clients, 3-cycle memory latency
        m_raccept = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            c_rvalid  = (k < 5) ? 4'b1111 : 4'b0000;
            m_rdvalid = (k >= 3 && k <= 7);
            m_rdata   = 32'hA0 + 32'(k - 3);
            #3;
            j = k - 3 - RL;
            exp_pend = ((k < 5) ? k : 5) - ((k - 3 < 0) ? 0 : ((k - 3 > 5) ? 5 : k - 3));
            chk($sformatf("rr_accept_%0d", k), 64'(c_raccept), (k < 5) ? 64'(1 << (k % 4)) : 64'd0);
            chk($sformatf("rr_raddr_%0d", k), 64'(m_raddr), (k < 5) ? 64'(32'h200 + (k % 4)) : 64'd0);
            chk($sformatf("rr_pend_%0d", k), 64'(rd_pending), 64'(exp_pend));
            chk($sformatf("rr_rready_%0d", k), 64'(c_rready), (j >= 0 && j <= 4) ? 64'(1 << (j % 4)) : 64'd0);
            if (j >= 0 && j <= 4) chk($sformatf("rr_rdata_%0d", k), 64'(c_rdata), 64'(32'hA0 + j));
        end
        step(); m_rdvalid = 1'b0; #3;
        chk("rr_drained", 64'(rd_pending), 64'd0);
        chk("rr_err", 64'(err), 64'd0);

        // Lock on client 2 while memory stalls; mode/sel changes ignored
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) begin mode = 1'b1; c_rvalid = 4'b0100; m_raccept = 1'b0; end
            if (i == 2) begin mode = 1'b0; sel = 2'd0; c_rvalid = 4'b0101; end
            #3;
            chk($sformatf("lock_rvalid_%0d", i), 64'(m_rvalid), 64'd1);
            chk($sformatf("lock_raddr_%0d", i), 64'(m_raddr), 64'h202);
            chk($sformatf("lock_accept_%0d", i), 64'(c_raccept), 64'd0);
        end
        step(); m_raccept = 1'b1; #3;
        chk("lock_release", 64'(c_raccept), 64'b0100);
        step(); c_rvalid = 4'b0001; #3;
        chk("after_lock_static", 64'(c_raccept), 64'b0001);
        chk("after_lock_addr", 64'(m_raddr), 64'h200);
        step(); c_rvalid = '0; mode = 1'b1; #3;
        chk("lock_pend", 64'(rd_pending), 64'd2);
        resp(4'b0100, 32'h55, "lock_r0");
        resp(4'b0001, 32'h66, "lock_r1");

        // Fill the tag FIFO, stall, then push+pop in one cycle
        for (int i = 0; i < 8; i++) begin
            step(); c_rvalid = 4'b0001; #3;
            chk($sformatf("fill_%0d", i), 64'(c_raccept), 64'b0001);
        end
        step(); #3;
        chk("full_pend", 64'(rd_pending), 64'd8);
        chk("full_block", 64'(m_rvalid), 64'd0);
        chk("full_noaccept", 64'(c_raccept), 64'd0);
        step(); m_rdvalid = 1'b1; m_rdata = 32'h77; #3;
        chk("pushpop_rvalid", 64'(m_rvalid), 64'd1);
        chk("pushpop_accept", 64'(c_raccept), 64'b0001);
        step(); m_rdvalid = 1'b0; c_rvalid = '0; #3;
        chk("pushpop_pend", 64'(rd_pending), 64'd8);
        for (int i = 0; i < 8; i++) resp(4'b0001, 32'h300 + i, $sformatf("drain%0d", i));
        step(); #3;
        chk("drain_pend", 64'(rd_pending), 64'd0);

        // Response with no outstanding read
        step(); m_rdvalid = 1'b1; #3;
        chk("orphan_rready", 64'(c_rready), 64'd0);
        chk("orphan_err_pre", 64'(err), 64'd0);
        step(); m_rdvalid = 1'b0; #3;
        chk("orphan_err", 64'(err), 64'd1);
        chk("orphan_rready_post", 64'(c_rready), 64'd0);
        step(); step(); #3;
        chk("err_sticky", 64'(err), 64'd1);
        step(); rst = 1'b1; #3;
        chk("err_cleared", 64'(err), 64'd0);
        step(); rst = 1'b0;

        // Reset with three reads outstanding, then a late response
        for (int i = 0; i < 3; i++) begin
            step(); c_rvalid = 4'b0001; m_raccept = 1'b1; #3;
            chk($sformatf("burst_%0d", i), 64'(c_raccept), 64'b0001);
        end
        step(); c_rvalid = '0; #3;
        chk("burst_pend", 64'(rd_pending), 64'd3);
        rst = 1'b1; #1;
        chk("midrst_pend", 64'(rd_pending), 64'd0);
        step(); rst = 1'b0;
        step(); m_rdvalid = 1'b1; #3;
        chk("late_rready", 64'(c_rready), 64'd0);
        step(); m_rdvalid = 1'b0; #3;
        chk("late_err", 64'(err), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
